// File: rtl/sc_max7219_pkg.sv
// Shared MAX7219 protocol constants and receiver FSM encoding.
package sc_max7219_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_LATCH     = 2'd3
    } rxState_t;

endpackage

// File: rtl/sc_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, with single-cycle rise/fall
// pulses derived from the synchronized level only.
module sc_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic syncOut,
    output logic riseOut,
    output logic fallOut
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= '0;
            prev_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], asyncIn};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign syncOut = chain_r[STAGES-1];
    assign riseOut = chain_r[STAGES-1] & ~prev_r;
    assign fallOut = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/sc_max7219_receiver.sv
// MAX7219 receive-side mirror: oversamples DIN/CLK/NCS, assembles 16-bit
// frames and decodes them into a shadow copy of the display register file.
module sc_max7219_receiver
    import sc_max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = sc_max7219_pkg::FRAME_BITS
) (
    input  logic       SC_MAX7219RX_CLOCK_50,
    input  logic       SC_MAX7219RX_RESET_InHigh,
    input  logic       SC_MAX7219RX_din_In,
    input  logic       SC_MAX7219RX_ncs_In,
    input  logic       SC_MAX7219RX_sclk_In,
    input  logic [2:0] SC_MAX7219RX_rdAddr_InBUS,
    output logic [7:0] SC_MAX7219RX_rdData_OutBUS,
    output logic [3:0] SC_MAX7219RX_intensity_OutBUS,
    output logic [2:0] SC_MAX7219RX_scanLimit_OutBUS,
    output logic [7:0] SC_MAX7219RX_decodeMode_OutBUS,
    output logic       SC_MAX7219RX_shutdown_OutHigh,
    output logic       SC_MAX7219RX_displayTest_OutHigh,
    output logic       SC_MAX7219RX_wordValid_OutHigh,
    output logic [3:0] SC_MAX7219RX_wordAddr_OutBUS,
    output logic [7:0] SC_MAX7219RX_wordData_OutBUS,
    output logic       SC_MAX7219RX_frameErr_OutHigh,
    output logic       SC_MAX7219RX_dout_Out
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    logic clk;
    logic rst;
    assign clk = SC_MAX7219RX_CLOCK_50;
    assign rst = SC_MAX7219RX_RESET_InHigh;

    logic dinSync_s;
    logic dinRise_s;
    logic dinFall_s;
    logic ncsSync_s;
    logic ncsRise_s;
    logic ncsFall_s;
    logic sclkSync_s;
    logic sclkRise_s;
    logic sclkFall_s;

    sc_sync_edge #(.STAGES(SYNC_STAGES)) uDinSync (
        .clk     (clk),
        .rst     (rst),
        .asyncIn (SC_MAX7219RX_din_In),
        .syncOut (dinSync_s),
        .riseOut (dinRise_s),
        .fallOut (dinFall_s)
    );

    sc_sync_edge #(.STAGES(SYNC_STAGES)) uNcsSync (
        .clk     (clk),
        .rst     (rst),
        .asyncIn (SC_MAX7219RX_ncs_In),
        .syncOut (ncsSync_s),
        .riseOut (ncsRise_s),
        .fallOut (ncsFall_s)
    );

    sc_sync_edge #(.STAGES(SYNC_STAGES)) uSclkSync (
        .clk     (clk),
        .rst     (rst),
        .asyncIn (SC_MAX7219RX_sclk_In),
        .syncOut (sclkSync_s),
        .riseOut (sclkRise_s),
        .fallOut (sclkFall_s)
    );

    rxState_t             state_r;
    logic [FRAME_BITS-1:0] shreg_r;
    logic [CNT_W-1:0]     bitCnt_r;
    logic                 dout_r;
    logic                 wordValid_r;
    logic                 frameErr_r;
    logic [3:0]           wordAddr_r;
    logic [7:0]           wordData_r;
    logic [7:0]           digit_r [0:7];
    logic [7:0]           decodeMode_r;
    logic [3:0]           intensity_r;
    logic [2:0]           scanLimit_r;
    logic                 shutdown_r;
    logic                 displayTest_r;
    logic [7:0]           rdData_r;

    // The shift register always holds the last 16 bits, so longer frames
    // naturally discard their leading bits.
    logic [3:0] frameAddr_s;
    logic [7:0] frameData_s;
    logic [2:0] digitIdx_s;
    assign frameAddr_s = shreg_r[11:8];
    assign frameData_s = shreg_r[7:0];
    assign digitIdx_s  = 3'(frameAddr_s - 4'd1);

    // Frame FSM: capture, validate and decode into the shadow register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_WAIT_IDLE;
            shreg_r       <= '0;
            bitCnt_r      <= '0;
            dout_r        <= 1'b0;
            wordValid_r   <= 1'b0;
            frameErr_r    <= 1'b0;
            wordAddr_r    <= 4'h0;
            wordData_r    <= 8'h00;
            decodeMode_r  <= 8'h00;
            intensity_r   <= 4'h0;
            scanLimit_r   <= 3'd0;
            shutdown_r    <= 1'b1;
            displayTest_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                digit_r[i] <= 8'h00;
            end
        end else begin
            wordValid_r <= 1'b0;
            frameErr_r  <= 1'b0;
            case (state_r)
                ST_WAIT_IDLE: begin
                    // Never lock onto a frame already in flight at reset release.
                    if (ncsSync_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (ncsFall_s) begin
                        shreg_r  <= '0;
                        bitCnt_r <= '0;
                        state_r  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ncsRise_s) begin
                        state_r <= ST_LATCH;
                    end else if (sclkRise_s) begin
                        shreg_r <= {shreg_r[FRAME_BITS-2:0], dinSync_s};
                        dout_r  <= shreg_r[FRAME_BITS-2];
                        if (bitCnt_r < CNT_FULL) begin
                            bitCnt_r <= bitCnt_r + 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    state_r <= ST_IDLE;
                    if (bitCnt_r < CNT_FULL) begin
                        frameErr_r <= 1'b1;
                    end else begin
                        wordValid_r <= 1'b1;
                        wordAddr_r  <= frameAddr_s;
                        wordData_r  <= frameData_s;
                        case (frameAddr_s)
                            ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                                digit_r[digitIdx_s] <= frameData_s;
                            ADDR_DECODE:    decodeMode_r  <= frameData_s;
                            ADDR_INTENSITY: intensity_r   <= frameData_s[3:0];
                            ADDR_SCANLIMIT: scanLimit_r   <= frameData_s[2:0];
                            ADDR_SHUTDOWN:  shutdown_r    <= ~frameData_s[0];
                            ADDR_TEST:      displayTest_r <= frameData_s[0];
                            default: ;
                        endcase
                    end
                end
                default: state_r <= ST_WAIT_IDLE;
            endcase
        end
    end

    // Digit readback port; a same-cycle write is seen one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData_r <= 8'h00;
        end else begin
            rdData_r <= digit_r[SC_MAX7219RX_rdAddr_InBUS];
        end
    end

    assign SC_MAX7219RX_rdData_OutBUS       = rdData_r;
    assign SC_MAX7219RX_intensity_OutBUS    = intensity_r;
    assign SC_MAX7219RX_scanLimit_OutBUS    = scanLimit_r;
    assign SC_MAX7219RX_decodeMode_OutBUS   = decodeMode_r;
    assign SC_MAX7219RX_shutdown_OutHigh    = shutdown_r;
    assign SC_MAX7219RX_displayTest_OutHigh = displayTest_r;
    assign SC_MAX7219RX_wordValid_OutHigh   = wordValid_r;
    assign SC_MAX7219RX_wordAddr_OutBUS     = wordAddr_r;
    assign SC_MAX7219RX_wordData_OutBUS     = wordData_r;
    assign SC_MAX7219RX_frameErr_OutHigh    = frameErr_r;
    assign SC_MAX7219RX_dout_Out            = dout_r;

    // Data-pin and clock-fall edges are not needed by the protocol.
    logic unusedEdges_s;
    assign unusedEdges_s = dinRise_s ^ dinFall_s ^ sclkSync_s ^ sclkFall_s;

endmodule
